// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: one outstanding access, optional wait states,
// byte-masked writes for program loading, error response on misaligned/out-of-range access.
module imem_responder #(
   parameter int INSTRUCTION = 32,
   parameter int ADDRESS     = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   request,
   input  logic                   we_re,
   input  logic [3:0]             mask,
   input  logic [ADDRESS-1:0]     address,
   input  logic [INSTRUCTION-1:0] data_in,
   output logic [INSTRUCTION-1:0] instruction_out,
   output logic                   valid,
   output logic                   busy,
   output logic                   error
);
   // state | meaning
   // IDLE  | no transaction in flight, ready to accept
   // WAIT  | request accepted, burning wait states, not accepting
   // RESP  | response presented (valid=1), may accept the next request

   localparam int                   AW  = $clog2(DEPTH);
   localparam logic [INSTRUCTION-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                 state;
   logic [3:0]             wait_cnt;
   logic [INSTRUCTION-1:0] pend_word;
   logic                   pend_err;

   logic [INSTRUCTION-1:0] mem [DEPTH];

   logic [ADDRESS-1:0]     word_addr;
   logic [AW-1:0]          idx;
   logic                   legal;
   logic                   accept;
   logic                   mem_we;
   logic [INSTRUCTION-1:0] acc_word;

   // Range check uses the whole word address so high address bits never alias into memory.
   assign word_addr = {2'b00, address[ADDRESS-1:2]};
   assign idx       = address[AW+1:2];
   assign legal     = (address[1:0] == 2'b00) && (word_addr < ADDRESS'(DEPTH));
   assign accept    = request && (state != WAIT);
   assign mem_we    = !rst && accept && legal && we_re;
   assign busy      = (state == WAIT);

   // Response word is fixed at acceptance; memory cannot change while the access is in flight.
   always_comb begin
      acc_word = NOP;
      if (legal) begin
         acc_word = mem[idx];
         if (we_re) begin
            for (int i = 0; i < 4; i++) begin
               if (mask[i]) acc_word[8*i +: 8] = data_in[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= acc_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         valid           <= 1'b0;
         error           <= 1'b0;
         instruction_out <= NOP;
         wait_cnt        <= 4'd0;
         pend_word       <= NOP;
         pend_err        <= 1'b0;
      end else begin
         valid <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  if (WAIT_STATES == 0) begin
                     state           <= RESP;
                     valid           <= 1'b1;
                     error           <= !legal;
                     instruction_out <= acc_word;
                  end else begin
                     state     <= WAIT;
                     wait_cnt  <= 4'(WAIT_STATES - 1);
                     pend_word <= acc_word;
                     pend_err  <= !legal;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state           <= RESP;
                  valid           <= 1'b1;
                  error           <= pend_err;
                  instruction_out <= pend_word;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-fetch memory interface: accepts the fetch stage's request/we_re/mask/address and returns instruction words to its instruction_fetch input.
- Word-organised synchronous memory, one outstanding transaction, configurable wait states.
- Byte-masked write path for program loading.
- Sits between the fetch stage and the instruction storage; also serves as the fetch-side memory model in the Verilator bench.

Parameters:
- INSTRUCTION, 32, data word width in bits; fixed at 32 (4 byte lanes).
- ADDRESS, 32, byte-address width.
- DEPTH, 1024, memory size in words.
- WAIT_STATES, 0, extra cycles inserted before each response (0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- request  input  1  transaction request from the fetch side.
- we_re  input  1  1 = write, 0 = read.
- mask  input  4  byte-lane enables for writes; bit i covers data bits [8i+7:8i]; ignored on reads.
- address  input  ADDRESS  byte address; word index = address[2+$clog2(DEPTH)-1:2].
- data_in  input  INSTRUCTION  write data.
- instruction_out  output  INSTRUCTION  response word.
- valid  output  1  response qualifier; high for exactly one cycle per accepted request.
- busy  output  1  high while a request cannot be accepted.
- error  output  1  qualified by valid; marks a misaligned or out-of-range access.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE, valid = 0, error = 0, busy = 0, instruction_out = 32'h00000013 (NOP), wait counter = 0.
  - Memory contents are not reset.
  - rst has priority over everything. A request presented in the reset cycle is dropped, and a write in that cycle does not commit.
- FSM states: IDLE, WAIT, RESP.
- Acceptance: a request is accepted at an edge where request = 1 and state is IDLE or RESP. It is never accepted in WAIT.
- busy = 1 exactly when state = WAIT (combinational from state).
- After acceptance:
  - WAIT_STATES = 0: next state RESP; valid is high the cycle after acceptance.
  - WAIT_STATES = N > 0: next state WAIT with counter = N-1. The counter decrements each cycle; when it reaches 0, the next state is RESP. valid rises N+1 cycles after acceptance.
- In RESP:
  - valid = 1 for this single cycle.
  - Next state follows the acceptance rules if request = 1, giving back-to-back throughput of 1 word/cycle when WAIT_STATES = 0. Otherwise next state is IDLE.
- Request latching: address, we_re, mask and data_in are latched at acceptance. Inputs are don't-care in WAIT.
- Illegal access: address[1:0] != 0 (misaligned) or word index >= DEPTH (out of range). Out-of-range check uses the full address, no aliasing.
  - No memory update.
  - Response has error = 1 and instruction_out = 32'h00000013.
- Legal write:
  - Commits on the acceptance edge, lanes per mask only.
  - mask = 0 is a legal no-op write.
  - Response returns the post-write word with error = 0.
- Legal read: response returns the stored word at response time, with error = 0.
- Read-after-write: a read accepted in the RESP cycle of a write to the same word returns the new data.
- Outside RESP: valid = 0 and error = 0. instruction_out holds the last response value.
- Reset mid-operation (WAIT or RESP): the transaction is abandoned and no valid is produced. A write already committed stays committed.

Test Plan:
- Reset, then read word 0 (WAIT_STATES=0) after writing 32'h00500093 with mask 4'b1111 → write response valid next cycle, instruction_out=32'h00500093, error=0; read returns 32'h00500093 one cycle after acceptance.
- Partial write: word at 0x8 holds 32'hAABBCCDD; write data_in=32'h11223344, mask=4'b0101 → read returns 32'hAA22CC44.
- Back-to-back reads of 0x0, 0x4, 0x8 on consecutive cycles, WAIT_STATES=0 → valid high three consecutive cycles with the matching words; busy stays 0.
- WAIT_STATES=3, read 0x4 → busy high 3 cycles, valid exactly 4 cycles after acceptance; a request held high during busy is accepted only in the RESP cycle.
- Illegal accesses: address 0x2, then address 4*DEPTH → both respond valid with error=1 and instruction_out=32'h00000013. A write to 0x2 leaves word 0 unchanged.
- Reset mid-operation: assert rst during WAIT (WAIT_STATES=2) → no valid pulse, busy=0 and instruction_out=32'h00000013 the cycle after. Write-then-reset in the same cycle leaves memory unchanged.
